// File: rtl/palette_lut_if.sv
// Write/lookup bus between the sprite index decoder and the palette LUT.
// The master drives the requests; the slave returns handshake, lookup results and status.
interface palette_lut_if #(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned PAL_W   = 2,
  parameter int unsigned COLOR_W = 24
);
  logic               i_wr_valid;
  logic               o_wr_ready;
  logic [PAL_W-1:0]   i_wr_pal;
  logic [IDX_W-1:0]   i_wr_idx;
  logic [COLOR_W-1:0] i_wr_color;
  logic               i_rd_valid;
  logic [PAL_W-1:0]   i_rd_pal;
  logic [IDX_W-1:0]   i_rd_idx;
  logic               o_rd_valid;
  logic [COLOR_W-1:0] o_rd_color;
  logic               o_rd_transparent;
  logic               o_busy;

  modport master (
    output i_wr_valid, i_wr_pal, i_wr_idx, i_wr_color,
    output i_rd_valid, i_rd_pal, i_rd_idx,
    input  o_wr_ready, o_rd_valid, o_rd_color, o_rd_transparent, o_busy
  );

  modport slave (
    input  i_wr_valid, i_wr_pal, i_wr_idx, i_wr_color,
    input  i_rd_valid, i_rd_pal, i_rd_idx,
    output o_wr_ready, o_rd_valid, o_rd_color, o_rd_transparent, o_busy
  );
endinterface

// File: rtl/palette_lut.sv
// Multi-bank writable colour palette: self-clears after reset, then serves one
// lookup per cycle with 2-cycle latency and a per-index transparency flag.
module palette_lut #(
  parameter int unsigned IDX_W           = 4,
  parameter int unsigned NUM_PAL         = 4,
  parameter int unsigned COLOR_W         = 24,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input logic          i_clk,
  input logic          i_rst,
  palette_lut_if.slave bus
);
  localparam int unsigned PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned DEPTH   = NUM_PAL * ENTRIES;
  localparam int unsigned ADDR_W  = PAL_W + IDX_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_clr_cnt;
  logic [CNT_W-1:0]   w_clr_cnt_nxt;
  logic               w_clr_we;

  logic               r_busy;
  logic               r_wr_ready;

  logic [COLOR_W-1:0] r_mem [DEPTH];

  logic               w_wr_fire;
  logic               w_wr_pal_ok;
  logic               w_rd_pal_ok;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_rd_addr;

  logic               r_s1_valid;
  logic               r_s1_transp;
  logic               r_s1_oor;
  logic [COLOR_W-1:0] r_s1_data;

  logic               r_rd_valid;
  logic [COLOR_W-1:0] r_rd_color;
  logic               r_rd_transp;

  assign w_wr_pal_ok = (32'(bus.i_wr_pal) < NUM_PAL);
  assign w_rd_pal_ok = (32'(bus.i_rd_pal) < NUM_PAL);
  assign w_wr_fire   = bus.i_wr_valid && r_wr_ready;
  assign w_wr_addr   = {bus.i_wr_pal, bus.i_wr_idx};
  assign w_rd_addr   = {bus.i_rd_pal, bus.i_rd_idx};

  // Next-state logic: sweep every address once, then serve traffic.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + CNT_W'(1);
        if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: ;
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_busy     <= 1'b1;
      r_wr_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_busy     <= (w_state_nxt == ST_CLEAR);
      r_wr_ready <= (w_state_nxt == ST_READY);
    end
  end

  // Storage; the stage-1 read samples before this edge's write lands (no bypass).
  always_ff @(posedge i_clk) begin
    r_s1_data <= r_mem[w_rd_addr];
    if (!i_rst) begin
      if (w_clr_we) begin
        r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (w_wr_fire && w_wr_pal_ok) begin
        r_mem[w_wr_addr] <= bus.i_wr_color;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_transp <= 1'b0;
      r_s1_oor    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_color  <= '0;
      r_rd_transp <= 1'b0;
    end else begin
      r_s1_valid  <= bus.i_rd_valid && (r_state == ST_READY);
      r_s1_transp <= (bus.i_rd_idx == IDX_W'(TRANSPARENT_IDX));
      r_s1_oor    <= !w_rd_pal_ok;
      r_rd_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        r_rd_color  <= r_s1_oor ? '0 : r_s1_data;
        r_rd_transp <= r_s1_transp | r_s1_oor;
      end
    end
  end

  assign bus.o_busy           = r_busy;
  assign bus.o_wr_ready       = r_wr_ready;
  assign bus.o_rd_valid       = r_rd_valid;
  assign bus.o_rd_color       = r_rd_color;
  assign bus.o_rd_transparent = r_rd_transp;
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: a 4-bank instance for the main scenarios and
// a 3-bank instance for the illegal-bank case.
module tb_palette_lut;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  palette_lut_if #(.IDX_W(4), .PAL_W(2), .COLOR_W(24)) a ();
  palette_lut_if #(.IDX_W(4), .PAL_W(2), .COLOR_W(24)) b ();

  palette_lut #(.IDX_W(4), .NUM_PAL(4), .COLOR_W(24), .TRANSPARENT_IDX(0)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .bus(a)
  );
  palette_lut #(.IDX_W(4), .NUM_PAL(3), .COLOR_W(24), .TRANSPARENT_IDX(0)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .bus(b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [1:0] pal, input logic [3:0] idx, input logic [23:0] col);
    a.i_wr_valid = 1'b1; a.i_wr_pal = pal; a.i_wr_idx = idx; a.i_wr_color = col;
    chk("wr_ready", 32'(a.o_wr_ready), 32'd1);
    tick();
    a.i_wr_valid = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [1:0] pal, input logic [3:0] idx,
                      input logic [23:0] exp_col, input logic exp_tr);
    a.i_rd_valid = 1'b1; a.i_rd_pal = pal; a.i_rd_idx = idx;
    tick();
    a.i_rd_valid = 1'b0;
    chk({tag, "_early"}, 32'(a.o_rd_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(a.o_rd_valid), 32'd1);
    chk({tag, "_color"}, 32'(a.o_rd_color), 32'(exp_col));
    chk({tag, "_transp"}, 32'(a.o_rd_transparent), 32'(exp_tr));
  endtask

  task automatic rd_b(input string tag, input logic [1:0] pal, input logic [3:0] idx,
                      input logic [23:0] exp_col, input logic exp_tr);
    b.i_rd_valid = 1'b1; b.i_rd_pal = pal; b.i_rd_idx = idx;
    tick();
    b.i_rd_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(b.o_rd_valid), 32'd1);
    chk({tag, "_color"}, 32'(b.o_rd_color), 32'(exp_col));
    chk({tag, "_transp"}, 32'(b.o_rd_transparent), 32'(exp_tr));
  endtask

  initial begin
    int  n;
    logic seen_valid;
    a.i_wr_valid = 1'b0; a.i_wr_pal = '0; a.i_wr_idx = '0; a.i_wr_color = '0;
    a.i_rd_valid = 1'b0; a.i_rd_pal = '0; a.i_rd_idx = '0;
    b.i_wr_valid = 1'b0; b.i_wr_pal = '0; b.i_wr_idx = '0; b.i_wr_color = '0;
    b.i_rd_valid = 1'b0; b.i_rd_pal = '0; b.i_rd_idx = '0;

    // 1: reset defaults and clear length
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(a.o_busy), 32'd1);
    chk("rst_wr_ready", 32'(a.o_wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(a.o_rd_valid), 32'd0);
    chk("rst_rd_color", 32'(a.o_rd_color), 32'd0);
    chk("rst_rd_transp", 32'(a.o_rd_transparent), 32'd0);
    // requests during clear must be ignored
    a.i_wr_valid = 1'b1; a.i_wr_pal = 2'd2; a.i_wr_idx = 4'd5; a.i_wr_color = 24'hFFFFFF;
    a.i_rd_valid = 1'b1;
    n = 0;
    seen_valid = 1'b0;
    while (a.o_busy && n < 200) begin
      tick();
      n++;
      if (a.o_rd_valid) seen_valid = 1'b1;
    end
    a.i_wr_valid = 1'b0; a.i_rd_valid = 1'b0;
    chk("clear_cycles", 32'(n), 32'd64);
    chk("clear_no_rd_valid", 32'(seen_valid), 32'd0);
    chk("ready_after_clear", 32'(a.o_wr_ready), 32'd1);
    tick();
    tick();
    rd_a("t1_b2i5", 2'd2, 4'd5, 24'h000000, 1'b0);

    // 2: write then back-to-back reads
    wr_a(2'd1, 4'd3, 24'h484B4D);
    a.i_rd_valid = 1'b1; a.i_rd_pal = 2'd1; a.i_rd_idx = 4'd3;
    tick();
    a.i_rd_idx = 4'd0;
    chk("t2_lat", 32'(a.o_rd_valid), 32'd0);
    tick();
    a.i_rd_valid = 1'b0;
    chk("t2_r0_valid", 32'(a.o_rd_valid), 32'd1);
    chk("t2_r0_color", 32'(a.o_rd_color), 32'h484B4D);
    chk("t2_r0_transp", 32'(a.o_rd_transparent), 32'd0);
    tick();
    chk("t2_r1_valid", 32'(a.o_rd_valid), 32'd1);
    chk("t2_r1_color", 32'(a.o_rd_color), 32'h000000);
    chk("t2_r1_transp", 32'(a.o_rd_transparent), 32'd1);
    tick();
    chk("t2_idle_valid", 32'(a.o_rd_valid), 32'd0);
    chk("t2_hold_color", 32'(a.o_rd_color), 32'h000000);

    // 3: bank isolation
    wr_a(2'd0, 4'd7, 24'hBABAB8);
    wr_a(2'd3, 4'd7, 24'h252525);
    rd_a("t3_b0", 2'd0, 4'd7, 24'hBABAB8, 1'b0);
    rd_a("t3_b3", 2'd3, 4'd7, 24'h252525, 1'b0);
    rd_a("t3_b1", 2'd1, 4'd7, 24'h000000, 1'b0);

    // 4: same-cycle read/write returns old data, next read returns new
    wr_a(2'd0, 4'd9, 24'h555656);
    a.i_wr_valid = 1'b1; a.i_wr_pal = 2'd0; a.i_wr_idx = 4'd9; a.i_wr_color = 24'h939494;
    a.i_rd_valid = 1'b1; a.i_rd_pal = 2'd0; a.i_rd_idx = 4'd9;
    tick();
    a.i_wr_valid = 1'b0;
    tick();
    a.i_rd_valid = 1'b0;
    chk("t4_old_color", 32'(a.o_rd_color), 32'h555656);
    tick();
    chk("t4_new_valid", 32'(a.o_rd_valid), 32'd1);
    chk("t4_new_color", 32'(a.o_rd_color), 32'h939494);

    // 5: reset in the middle of a read stream
    a.i_rd_valid = 1'b1; a.i_rd_pal = 2'd1; a.i_rd_idx = 4'd3;
    tick();
    rst = 1'b1;
    a.i_wr_valid = 1'b1; a.i_wr_pal = 2'd1; a.i_wr_idx = 4'd4; a.i_wr_color = 24'hABCDEF;
    tick();
    rst = 1'b0;
    a.i_wr_valid = 1'b0;
    chk("t5_valid_after_rst", 32'(a.o_rd_valid), 32'd0);
    chk("t5_busy", 32'(a.o_busy), 32'd1);
    tick();
    a.i_rd_valid = 1'b0;
    n = 0;
    seen_valid = 1'b0;
    while (a.o_busy && n < 200) begin
      if (a.o_rd_valid) seen_valid = 1'b1;
      tick();
      n++;
    end
    chk("t5_no_valid", 32'(seen_valid), 32'd0);
    chk("t5_clear_cycles", 32'(n), 32'd63);
    rd_a("t5_b1i3", 2'd1, 4'd3, 24'h000000, 1'b0);
    rd_a("t5_b1i4", 2'd1, 4'd4, 24'h000000, 1'b0);
    rd_a("t5_b3i7", 2'd3, 4'd7, 24'h000000, 1'b0);

    // 6: illegal bank on the 3-bank instance
    chk("t6_ready", 32'(b.o_wr_ready), 32'd1);
    b.i_wr_valid = 1'b1; b.i_wr_pal = 2'd2; b.i_wr_idx = 4'd5; b.i_wr_color = 24'h123456;
    tick();
    b.i_wr_pal = 2'd3; b.i_wr_color = 24'hFFFFFF;
    chk("t6_bad_wr_ready", 32'(b.o_wr_ready), 32'd1);
    tick();
    b.i_wr_valid = 1'b0;
    rd_b("t6_oor", 2'd3, 4'd5, 24'h000000, 1'b1);
    rd_b("t6_b2", 2'd2, 4'd5, 24'h123456, 1'b0);
    rd_b("t6_b0", 2'd0, 4'd5, 24'h000000, 1'b0);
    rd_b("t6_b1", 2'd1, 4'd5, 24'h000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
